// File: rtl/ej32_pkg.sv
// ---------------------------------------------------------------------------
// ej32_pkg
// Shared types and constants for the ej32 core slice used by the bytecode
// prefetch queue.
//   IU_ASZ     : instruction-unit address width
//   iu_addr_t  : instruction byte address (fetch address, opcode address)
//   PF_DEPTH   : prefetch FIFO depth in bytes (power of two, >= 4)
//   pf_cnt_t   : buffered byte count, wide enough to hold PF_DEPTH
// ---------------------------------------------------------------------------
package ej32_pkg;

   localparam int IU_ASZ = 17;
   typedef logic [IU_ASZ-1:0] iu_addr_t;

   localparam int PF_DEPTH = 4;
   localparam int PF_CW    = $clog2(PF_DEPTH + 1);
   typedef logic [PF_CW-1:0] pf_cnt_t;

endpackage : ej32_pkg

// File: rtl/ej32_pf_fifo.sv
// ---------------------------------------------------------------------------
// ej32_pf_fifo
// Byte FIFO for the prefetch queue. One write port, one multi-pop read port
// that consumes 0..3 bytes per cycle and exposes the three oldest bytes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : discard all contents (branch redirect)
//   i_wr, i_wd   : push one byte at the tail
//   i_pop        : bytes consumed this cycle (0..3)
//   o_pop_ok     : i_pop fits in the current count (pop is applied)
//   o_d0..o_d2   : head, head+1, head+2 bytes; 0 when not buffered
//   o_cnt        : buffered byte count
//   o_err        : one-cycle pulse after a pop larger than the count
// ---------------------------------------------------------------------------
module ej32_pf_fifo
   import ej32_pkg::*;
#(
   parameter int DEPTH = PF_DEPTH
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_clr,
   input  logic                       i_wr,
   input  logic [7:0]                 i_wd,
   input  logic [1:0]                 i_pop,
   output logic                       o_pop_ok,
   output logic [7:0]                 o_d0,
   output logic [7:0]                 o_d1,
   output logic [7:0]                 o_d2,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt,
   output logic                       o_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [7:0]    r_mem [DEPTH];
   logic [PW-1:0] r_head;
   logic [PW-1:0] r_tail;
   logic [CW-1:0] r_cnt;
   logic          r_err;

   logic [CW-1:0] w_pop_n;
   logic [PW-1:0] w_h1;
   logic [PW-1:0] w_h2;

   // An oversized pop leaves the FIFO untouched and only raises err.
   assign o_pop_ok = (CW'(i_pop) <= r_cnt);
   assign w_pop_n  = o_pop_ok ? CW'(i_pop) : '0;

   // Pointer arithmetic wraps naturally because DEPTH is a power of two.
   assign w_h1 = r_head + PW'(1);
   assign w_h2 = r_head + PW'(2);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_head <= '0;
         r_tail <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_err  <= ~o_pop_ok;
         r_head <= r_head + PW'(w_pop_n);
         if (i_wr) begin
            r_tail <= r_tail + PW'(1);
         end
         r_cnt  <= r_cnt + CW'(i_wr) - w_pop_n;
      end
   end

   // NOTE: the byte storage is deliberately not reset; stale entries are
   // never visible because every read is qualified by the count.
   always_ff @(posedge i_clk) begin
      if (i_wr) begin
         r_mem[r_tail] <= i_wd;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through it can infer a latch.
   always_comb begin
      o_d0 = '0;
      o_d1 = '0;
      o_d2 = '0;
      if (r_cnt >= CW'(1)) o_d0 = r_mem[r_head];
      if (r_cnt >= CW'(2)) o_d1 = r_mem[w_h1];
      if (r_cnt >= CW'(3)) o_d2 = r_mem[w_h2];
   end

   assign o_cnt = r_cnt;
   assign o_err = r_err;

endmodule : ej32_pf_fifo

// File: rtl/ej32_prefetch.sv
// ---------------------------------------------------------------------------
// ej32_prefetch
// Bytecode prefetch queue between the 8-bit SPRAM bus and the decoder.
// Fetches sequential bytes ahead of execution into a small FIFO, presents
// opcode + two peek bytes, and drops everything on a branch redirect.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_en                : fetch enable (set once the ROM copy is done)
//   i_flush, i_flush_a  : branch redirect strobe and target address
//   i_mem_gnt           : bus granted to the prefetcher this cycle
//   o_mem_req, o_mem_a  : fetch request and byte address
//   i_mem_d             : read data, valid the cycle after an accept
//   i_pop               : bytes consumed by the decoder (0..3)
//   o_op_valid, o_op    : head byte present / head byte
//   o_op1, o_op2        : head+1 / head+2 bytes, 0 when not buffered
//   o_op_a              : address of the head byte
//   o_avail             : buffered byte count
//   o_err               : one-cycle pulse on a pop larger than o_avail
// ---------------------------------------------------------------------------
module ej32_prefetch
   import ej32_pkg::*;
#(
   parameter int             ASZ   = IU_ASZ,
   parameter int             DEPTH = PF_DEPTH,
   parameter logic [ASZ-1:0] COLD  = '0
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_en,
   input  logic                       i_flush,
   input  logic [ASZ-1:0]             i_flush_a,
   input  logic                       i_mem_gnt,
   output logic                       o_mem_req,
   output logic [ASZ-1:0]             o_mem_a,
   input  logic [7:0]                 i_mem_d,
   input  logic [1:0]                 i_pop,
   output logic                       o_op_valid,
   output logic [7:0]                 o_op,
   output logic [7:0]                 o_op1,
   output logic [7:0]                 o_op2,
   output logic [ASZ-1:0]             o_op_a,
   output logic [$clog2(DEPTH+1)-1:0] o_avail,
   output logic                       o_err
);

   localparam int            CW   = $clog2(DEPTH + 1);
   localparam logic [CW:0]   FULL = (CW+1)'(DEPTH);

   logic [ASZ-1:0] r_fa;
   logic [ASZ-1:0] r_op_a;
   logic           r_inflight;

   logic [CW:0]    w_occ;
   logic           w_accept;
   logic           w_wr;
   logic           w_pop_ok;

   // Buffered plus in-flight bytes; one extra bit so DEPTH itself fits.
   assign w_occ     = {1'b0, o_avail} + {{CW{1'b0}}, r_inflight};
   assign o_mem_req = i_en & ~i_flush & (w_occ < FULL);
   assign w_accept  = o_mem_req & i_mem_gnt;
   assign o_mem_a   = r_fa;

   // A flush in the accept cycle cannot happen (mem_req is masked), so only
   // a flush in the return cycle needs to squash the landing byte.
   assign w_wr = r_inflight & ~i_flush;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fa       <= COLD;
         r_op_a     <= COLD;
         r_inflight <= 1'b0;
      end else if (i_flush) begin
         r_fa       <= i_flush_a;
         r_op_a     <= i_flush_a;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_fa <= r_fa + ASZ'(1);
         end
         if (w_pop_ok) begin
            r_op_a <= r_op_a + ASZ'(i_pop);
         end
      end
   end

   ej32_pf_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clr    (i_flush),
      .i_wr     (w_wr),
      .i_wd     (i_mem_d),
      .i_pop    (i_pop),
      .o_pop_ok (w_pop_ok),
      .o_d0     (o_op),
      .o_d1     (o_op1),
      .o_d2     (o_op2),
      .o_cnt    (o_avail),
      .o_err    (o_err)
   );

   assign o_op_valid = (o_avail != '0);
   assign o_op_a     = r_op_a;

endmodule : ej32_prefetch

// File: tb/tb_ej32_prefetch.sv
// ---------------------------------------------------------------------------
// tb_ej32_prefetch
// Self-checking bench for ej32_prefetch. The bench acts as the SPRAM (it
// answers accepted requests one cycle later) and keeps a queue-based model
// of the prefetcher: a byte queue, a fetch address and one pending return.
// ---------------------------------------------------------------------------
module tb_ej32_prefetch;
   import ej32_pkg::*;

   localparam int       ASZ   = IU_ASZ;
   localparam int       DEPTH = PF_DEPTH;
   localparam iu_addr_t COLD  = '0;

   logic     clk = 1'b0;
   always #5 clk = ~clk;

   logic     rst     = 1'b1;
   logic     en      = 1'b0;
   logic     flush   = 1'b0;
   iu_addr_t flush_a = '0;
   logic     mem_gnt = 1'b0;
   logic     mem_req;
   iu_addr_t mem_a;
   logic [7:0] mem_d = 8'h00;
   logic [1:0] pop   = 2'd0;
   logic     op_valid;
   logic [7:0] op, op1, op2;
   iu_addr_t op_a;
   pf_cnt_t  avail;
   logic     err;

   ej32_prefetch #(
      .ASZ   (ASZ),
      .DEPTH (DEPTH),
      .COLD  (COLD)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_flush    (flush),
      .i_flush_a  (flush_a),
      .i_mem_gnt  (mem_gnt),
      .o_mem_req  (mem_req),
      .o_mem_a    (mem_a),
      .i_mem_d    (mem_d),
      .i_pop      (pop),
      .o_op_valid (op_valid),
      .o_op       (op),
      .o_op1      (op1),
      .o_op2      (op2),
      .o_op_a     (op_a),
      .o_avail    (avail),
      .o_err      (err)
   );

   // Memory image shared by the bus responder and the model.
   logic [7:0] mem [0:(1<<ASZ)-1];

   // Reference model state.
   logic [7:0] q[$];
   iu_addr_t   m_fa     = COLD;
   iu_addr_t   m_opa    = COLD;
   bit         m_pend   = 1'b0;
   iu_addr_t   m_pend_a = '0;
   bit         m_err    = 1'b0;

   int n_vec = 0;
   int n_bad = 0;

   function automatic logic exp_req();
      return en && !flush && ((q.size() + int'(m_pend)) < DEPTH);
   endfunction

   function automatic logic [7:0] exp_b(input int k);
      if (q.size() > k) return q[k];
      return 8'h00;
   endfunction

   // Drive inputs just after the falling edge, let combinational outputs settle.
   task automatic set_in(input logic r, input logic e, input logic f,
                         input iu_addr_t fa, input logic g, input logic [1:0] p);
      @(negedge clk);
      rst = r; en = e; flush = f; flush_a = fa; mem_gnt = g; pop = p;
      #1;
   endtask

   // Clock edge: memory answers the DUT's real bus request, model advances.
   task automatic adv();
      bit       bus_acc;
      iu_addr_t bus_a;
      bit       m_acc;
      bus_acc = mem_req & mem_gnt;
      bus_a   = mem_a;
      m_acc   = exp_req() && mem_gnt;
      @(posedge clk);
      if (rst) begin
         q.delete();
         m_fa = COLD; m_opa = COLD; m_pend = 1'b0; m_err = 1'b0;
      end else if (flush) begin
         q.delete();
         m_fa = flush_a; m_opa = flush_a; m_pend = 1'b0; m_err = 1'b0;
      end else begin
         if (int'(pop) > q.size()) begin
            m_err = 1'b1;
         end else begin
            m_err = 1'b0;
            repeat (int'(pop)) void'(q.pop_front());
            m_opa = m_opa + iu_addr_t'(pop);
         end
         if (m_pend) q.push_back(mem[m_pend_a]);
         m_pend = m_acc;
         if (m_acc) begin
            m_pend_a = m_fa;
            m_fa     = m_fa + iu_addr_t'(1);
         end
      end
      #1;
      mem_d = bus_acc ? mem[bus_a] : 8'($urandom);
   endtask

   task automatic test_reset(input string tag);
      repeat (3) begin
         set_in(1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd0);
         adv();
      end
      set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 2'd0);
      n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL %s mem_req got %b exp 0", tag, mem_req); end
      n_vec++; if (mem_a !== COLD) begin n_bad++; $display("FAIL %s mem_a got %h exp %h", tag, mem_a, COLD); end
      n_vec++; if (op_a !== COLD) begin n_bad++; $display("FAIL %s op_a got %h exp %h", tag, op_a, COLD); end
      n_vec++; if (avail !== '0) begin n_bad++; $display("FAIL %s avail got %0d exp 0", tag, avail); end
      n_vec++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL %s op_valid got %b exp 0", tag, op_valid); end
      n_vec++; if ({op, op1, op2} !== 24'h0) begin n_bad++; $display("FAIL %s ops got %h %h %h exp 0", tag, op, op1, op2); end
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL %s err got %b exp 0", tag, err); end
      adv();
   endtask

   task automatic test_cold_start();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
         n_vec++; if (mem_req !== (i < 4)) begin n_bad++; $display("FAIL cold_req[%0d] got %b exp %b", i, mem_req, (i < 4)); end
         if (i < 4) begin
            n_vec++; if (mem_a !== iu_addr_t'(i)) begin n_bad++; $display("FAIL cold_mem_a[%0d] got %h exp %h", i, mem_a, i); end
         end
         adv();
      end
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL cold_full_req got %b exp 0", mem_req); end
      n_vec++; if ({op, op1, op2} !== {8'd10, 8'd11, 8'd12}) begin n_bad++; $display("FAIL cold_ops got %0d %0d %0d exp 10 11 12", op, op1, op2); end
      n_vec++; if (avail !== pf_cnt_t'(4)) begin n_bad++; $display("FAIL cold_avail got %0d exp 4", avail); end
      n_vec++; if (op_a !== iu_addr_t'(0)) begin n_bad++; $display("FAIL cold_op_a got %h exp 0", op_a); end
      adv();
   endtask

   task automatic test_multi_pop();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd3);
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd2);
      n_vec++; if (op !== 8'd13) begin n_bad++; $display("FAIL mpop_op got %0d exp 13", op); end
      n_vec++; if (op_a !== iu_addr_t'(3)) begin n_bad++; $display("FAIL mpop_op_a got %h exp 3", op_a); end
      n_vec++; if (avail !== pf_cnt_t'(1)) begin n_bad++; $display("FAIL mpop_avail got %0d exp 1", avail); end
      n_vec++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mpop_req got %b exp 1", mem_req); end
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_pop_err got %b exp 1", err); end
      n_vec++; if (avail !== pf_cnt_t'(1)) begin n_bad++; $display("FAIL illegal_pop_avail got %0d exp 1", avail); end
      n_vec++; if (op !== 8'd13) begin n_bad++; $display("FAIL illegal_pop_op got %0d exp 13", op); end
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_pulse got %b exp 0", err); end
      n_vec++; if (op1 !== 8'd14) begin n_bad++; $display("FAIL mpop_op1 got %0d exp 14", op1); end
      adv();
   endtask

   task automatic test_flush_inflight();
      for (int i = 0; i < 3; i++) begin
         set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
         adv();
      end
      set_in(1'b0, 1'b1, 1'b1, iu_addr_t'('h100), 1'b1, 2'd0);
      n_vec++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL flush_req got %b exp 0", mem_req); end
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (mem_a !== iu_addr_t'('h100)) begin n_bad++; $display("FAIL flush_mem_a got %h exp 100", mem_a); end
      n_vec++; if (avail !== '0) begin n_bad++; $display("FAIL flush_avail got %0d exp 0", avail); end
      n_vec++; if (op_a !== iu_addr_t'('h100)) begin n_bad++; $display("FAIL flush_op_a got %h exp 100", op_a); end
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (op_valid !== 1'b0) begin n_bad++; $display("FAIL flush_squash got op_valid %b exp 0", op_valid); end
      adv();
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if (op_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid got %b exp 1", op_valid); end
      n_vec++; if (op !== mem['h100]) begin n_bad++; $display("FAIL flush_op got %h exp %h", op, mem['h100]); end
      n_vec++; if (avail !== pf_cnt_t'(1)) begin n_bad++; $display("FAIL flush_cnt got %0d exp 1", avail); end
      adv();
   endtask

   task automatic test_grant_stall();
      iu_addr_t frozen = '0;
      for (int i = 0; i < 20; i++) begin
         logic g;
         logic [1:0] p;
         g = !(i >= 6 && i < 11);
         p = (q.size() > 0) ? 2'd1 : 2'd0;
         set_in(1'b0, 1'b1, 1'b0, '0, g, p);
         if (i == 6) frozen = m_fa;
         if (i > 6 && i < 11) begin
            n_vec++; if (mem_a !== frozen) begin n_bad++; $display("FAIL stall_frozen[%0d] got %h exp %h", i, mem_a, frozen); end
         end
         n_vec++; if (mem_a !== m_fa) begin n_bad++; $display("FAIL stall_mem_a[%0d] got %h exp %h", i, mem_a, m_fa); end
         n_vec++; if (op !== exp_b(0)) begin n_bad++; $display("FAIL stall_op[%0d] got %h exp %h", i, op, exp_b(0)); end
         n_vec++; if (avail !== pf_cnt_t'(q.size())) begin n_bad++; $display("FAIL stall_avail[%0d] got %0d exp %0d", i, avail, q.size()); end
         n_vec++; if (op_a !== m_opa) begin n_bad++; $display("FAIL stall_op_a[%0d] got %h exp %h", i, op_a, m_opa); end
         adv();
      end
   endtask

   task automatic test_wrap();
      mem['h1FFFE] = 8'hAA;
      mem['h1FFFF] = 8'hBB;
      mem[0]       = 8'hCC;
      set_in(1'b0, 1'b1, 1'b1, iu_addr_t'('h1FFFE), 1'b1, 2'd0);
      adv();
      for (int i = 0; i < 5; i++) begin
         set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
         if (i == 2) begin
            n_vec++; if (mem_a !== iu_addr_t'(0)) begin n_bad++; $display("FAIL wrap_mem_a got %h exp 0", mem_a); end
         end
         adv();
      end
      set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd0);
      n_vec++; if ({op, op1, op2} !== 24'hAABBCC) begin n_bad++; $display("FAIL wrap_ops got %h %h %h exp AA BB CC", op, op1, op2); end
      n_vec++; if (op_a !== iu_addr_t'('h1FFFE)) begin n_bad++; $display("FAIL wrap_op_a got %h exp 1FFFE", op_a); end
      adv();
   endtask

   task automatic test_steady();
      for (int i = 0; i < 40; i++) begin
         set_in(1'b0, 1'b1, 1'b0, '0, 1'b1, 2'd1);
         n_vec++; if (op !== exp_b(0)) begin n_bad++; $display("FAIL steady_op[%0d] got %h exp %h", i, op, exp_b(0)); end
         n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL steady_err[%0d] got %b exp 0", i, err); end
         if (i >= 5) begin
            n_vec++; if (avail !== pf_cnt_t'(q.size()) || avail === '0) begin n_bad++; $display("FAIL steady_avail[%0d] got %0d exp %0d nonzero", i, avail, q.size()); end
         end
         adv();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         logic       r, e, f, g;
         logic [1:0] p;
         iu_addr_t   fa;
         r  = ($urandom_range(0, 63) == 0);
         e  = ($urandom_range(0, 7) != 0);
         f  = ($urandom_range(0, 15) == 0);
         g  = ($urandom_range(0, 3) != 0);
         fa = iu_addr_t'($urandom);
         p  = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0 && int'(p) > q.size()) p = 2'(q.size());
         set_in(r, e, f, fa, g, p);
         n_vec++; if (mem_req !== exp_req()) begin n_bad++; $display("FAIL rnd_req[%0d] got %b exp %b", i, mem_req, exp_req()); end
         n_vec++; if (mem_a !== m_fa) begin n_bad++; $display("FAIL rnd_mem_a[%0d] got %h exp %h", i, mem_a, m_fa); end
         n_vec++; if (avail !== pf_cnt_t'(q.size())) begin n_bad++; $display("FAIL rnd_avail[%0d] got %0d exp %0d", i, avail, q.size()); end
         n_vec++; if (op_valid !== (q.size() > 0)) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, op_valid, (q.size() > 0)); end
         n_vec++; if ({op, op1, op2} !== {exp_b(0), exp_b(1), exp_b(2)}) begin n_bad++; $display("FAIL rnd_ops[%0d] got %h %h %h exp %h %h %h", i, op, op1, op2, exp_b(0), exp_b(1), exp_b(2)); end
         n_vec++; if (op_a !== m_opa) begin n_bad++; $display("FAIL rnd_op_a[%0d] got %h exp %h", i, op_a, m_opa); end
         n_vec++; if (err !== m_err) begin n_bad++; $display("FAIL rnd_err[%0d] got %b exp %b", i, err, m_err); end
         adv();
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << ASZ); i++) begin
         mem[i] = 8'((i * 37) ^ (i >> 7));
      end
      for (int i = 0; i < 8; i++) begin
         mem[i] = 8'(10 + i);
      end

      test_reset("reset_cold");
      test_cold_start();
      test_multi_pop();
      test_reset("reset_mid");
      test_flush_inflight();
      test_grant_stall();
      test_wrap();
      test_steady();
      test_random();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_ej32_prefetch

// File: doc/ej32_prefetch.md
Name: ej32_prefetch

Overview:
- Bytecode prefetch queue between the 8-bit SPRAM bus and the decoder unit, downstream of the instruction-address/ROM-copy logic.
- Once enabled after the ROM image copy, it fetches bytes sequentially ahead of execution into a small FIFO.
- Presents the current opcode plus two peek operand bytes to the decoder.
- Discards all buffered and in-flight bytes on a branch redirect.

Parameters:
ASZ, 17, instruction address width in bits
DEPTH, 4, FIFO depth in bytes; power of two, minimum 4
COLD, 'h0, fetch address loaded at reset

Ports:
clk  in  1  system clock; all state on posedge
rst  in  1  synchronous reset, active-high
en  in  1  fetch enable; high once the ROM copy completes
flush  in  1  branch redirect strobe
flush_a  in  ASZ  redirect target address
mem_gnt  in  1  bus granted to the prefetcher this cycle; low while load/store owns the bus
mem_req  out  1  fetch request
mem_a  out  ASZ  fetch byte address
mem_d  in  8  read data, valid the cycle after an accepted request
pop  in  2  bytes consumed by the decoder this cycle (0..3)
op_valid  out  1  avail >= 1
op  out  8  head byte (opcode)
op1  out  8  head+1 byte; 0 when avail < 2
op2  out  8  head+2 byte; 0 when avail < 3
op_a  out  ASZ  address of the head byte
avail  out  $clog2(DEPTH+1)  buffered byte count
err  out  1  one-cycle pulse on illegal pop

Behaviour:
- Reset values: fa (fetch address) = COLD, op_a = COLD, mem_a = COLD; mem_req, op_valid, avail, err and all FIFO pointers = 0; op, op1 and op2 = 0.
- mem_a always equals fa.
- mem_req = en & ~flush & (avail + inflight < DEPTH).
- A request is accepted in a cycle only when mem_req & mem_gnt.
- On accept: fa <= fa+1, wrapping 2^ASZ-1 -> 0, and the inflight flag is set for one cycle.
- Return handling: in the cycle after an accepted request, mem_d is written at the FIFO tail at the clock edge, unless a flush occurred in the accept cycle or the return cycle. A squashed return is dropped silently.
- Pop: when pop <= avail, advance head by pop and set op_a <= op_a + pop (wrapping).
- Illegal pop: when pop > avail, make no FIFO change and pulse err for one cycle.
- Simultaneous write and pop in one cycle: avail <= avail + 1 - pop. Head and tail pointers are independent and wrap modulo DEPTH.
- Flush has top priority over pop, write and accept:
  - avail <= 0, head and tail reset, inflight cleared;
  - fa <= flush_a, op_a <= flush_a.
- Flush latency:
  - flush sampled at edge E0;
  - request for flush_a issued in cycle E0..E1, if granted;
  - byte captured at E2;
  - op_valid = 1 after E2.
- Sequential throughput: 1 byte/cycle while mem_gnt is held high.
- mem_gnt low: no accept, fa holds, buffered data is retained. A return already in flight still lands.
- en low: no new requests; FIFO contents and an in-flight return are kept.
- Full FIFO (avail + inflight = DEPTH): mem_req = 0. Never overwrite.
- Reset mid-fetch: a pending return is discarded and all state returns to reset values.

Decomposition:
- ej32_pkg additions:
  - PF_DEPTH constant;
  - pf_cnt_t typedef for the count width;
  - existing IU address type for fa and op_a.
- Sub-module ej32_pf_fifo: byte FIFO with a multi-pop read port exposing head, head+1 and head+2, plus count. The parent holds fetch-address, inflight and flush control.

Test Plan:
- Cold start: rst 3 cycles, then en=1, mem_gnt=1, memory[0..7]=10..17 -> mem_a 0,1,2,3; after four accepts mem_req drops. Then op=10, op1=11, op2=12, avail=4, op_a=0.
- Multi-pop: pop=3 with avail=4 -> next cycle op=13, op_a=3, avail=1 plus the incoming byte. Then pop=2 with avail=1 -> err pulses, avail unchanged.
- Flush with byte in flight: accept at addr 2, flush_a='h100 in the return cycle -> byte from 2 dropped; mem_a='h100 next cycle; op=mem['h100] valid 2 cycles after flush; op_a='h100.
- Grant stall: mem_gnt low 5 cycles mid-stream -> fa frozen, the single in-flight byte still captured, no duplicate or skipped bytes after regrant.
- Wrap: flush_a='h1FFFE, memory at 'h1FFFE, 'h1FFFF, 0 = AA, BB, CC -> op, op1, op2 = AA, BB, CC; mem_a wraps to 0.
- Steady state pop=1 each cycle with mem_gnt=1 -> avail stable and nonzero, op sequence matches memory order, err never asserted.
